// File: rtl/lfu_pkg.sv
// Shared definitions for the LFU replacement path: counter width, scan FSM
// states and the victim-index width helper.
package lfu_pkg;

  // Usage counter width shared with the per-way counter block.
  localparam int unsigned CntW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  // Index width for n ways; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lfu_victim_select_if.sv
// Request/result bundle between the refill controller and lfu_victim_select.
// Build option: LFU_LOCK_EN adds lock_mask (per-way lock, snapshotted with
// valid_mask).
interface lfu_victim_select_if
  import lfu_pkg::*;
#(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned CNT_W = CntW,
  parameter int unsigned IDX_W = idx_width(SIZE)
);

  logic                  req;
  logic [SIZE*CNT_W-1:0] cnt_flat;
  logic [SIZE-1:0]       valid_mask;
`ifdef LFU_LOCK_EN
  logic [SIZE-1:0]       lock_mask;
`endif
  logic                  busy;
  logic                  done;
  logic [IDX_W-1:0]      victim_idx;
  logic [CNT_W-1:0]      victim_cnt;
  logic                  victim_invalid;
  logic                  no_victim;

`ifdef LFU_LOCK_EN
  modport master (
    output req, cnt_flat, valid_mask, lock_mask,
    input  busy, done, victim_idx, victim_cnt, victim_invalid, no_victim
  );

  modport slave (
    input  req, cnt_flat, valid_mask, lock_mask,
    output busy, done, victim_idx, victim_cnt, victim_invalid, no_victim
  );
`else
  modport master (
    output req, cnt_flat, valid_mask,
    input  busy, done, victim_idx, victim_cnt, victim_invalid, no_victim
  );

  modport slave (
    input  req, cnt_flat, valid_mask,
    output busy, done, victim_idx, victim_cnt, victim_invalid, no_victim
  );
`endif

endinterface

// File: rtl/lfu_min_cmp.sv
// Combinational eligibility and compare of one way against the running best.
module lfu_min_cmp
  import lfu_pkg::*;
#(
  parameter int unsigned CNT_W = CntW
) (
  input  logic [CNT_W-1:0] way_cnt_i,
  input  logic             way_valid_i,
  input  logic             way_lock_i,
  input  logic [CNT_W-1:0] best_cnt_i,
  input  logic             found_i,
  output logic             invalid_o,
  output logic             better_o
);

  logic eligible;

  // Invalid ways win outright; the first eligible way always loads best so an
  // all-ones count can still be chosen. Strict compare keeps the lowest index on ties.
  always_comb begin
    invalid_o = !way_valid_i;
    eligible  = way_valid_i && !way_lock_i;
    better_o  = eligible && (!found_i || (way_cnt_i < best_cnt_i));
  end

endmodule

// File: rtl/lfu_victim_select.sv
// LFU victim selection: snapshots all way counts on request, scans one way per
// cycle and returns the first invalid way or the lowest-count eligible way.
// Build option: LFU_LOCK_EN enables per-way locking and the no_victim result.
module lfu_victim_select
  import lfu_pkg::*;
#(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned CNT_W = CntW
) (
  input logic                clk,
  input logic                rst_n,
  lfu_victim_select_if.slave bus
);

  localparam int unsigned      IDX_W   = idx_width(SIZE);
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(SIZE - 1);

  state_e state_q, state_d;

  logic [CNT_W-1:0] snap_cnt_q [SIZE];
  logic [CNT_W-1:0] snap_cnt_d [SIZE];
  logic [SIZE-1:0]  snap_valid_q, snap_valid_d;
`ifdef LFU_LOCK_EN
  logic [SIZE-1:0]  snap_lock_q, snap_lock_d;
  logic             vic_none_q, vic_none_d;
`endif

  logic [IDX_W-1:0] k_q, k_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic             found_q, found_d;

  logic [IDX_W-1:0] vic_idx_q, vic_idx_d;
  logic [CNT_W-1:0] vic_cnt_q, vic_cnt_d;
  logic             vic_inv_q, vic_inv_d;

  logic [CNT_W-1:0] cur_cnt;
  logic             cur_valid;
  logic             cur_lock;
  logic             cur_invalid;
  logic             cur_better;
  logic             scan_end;

  assign cur_cnt   = snap_cnt_q[k_q];
  assign cur_valid = snap_valid_q[k_q];
`ifdef LFU_LOCK_EN
  assign cur_lock  = snap_lock_q[k_q];
`else
  assign cur_lock  = 1'b0;
`endif

  lfu_min_cmp #(
    .CNT_W (CNT_W)
  ) u_min_cmp (
    .way_cnt_i   (cur_cnt),
    .way_valid_i (cur_valid),
    .way_lock_i  (cur_lock),
    .best_cnt_i  (best_cnt_q),
    .found_i     (found_q),
    .invalid_o   (cur_invalid),
    .better_o    (cur_better)
  );

  // Scan finishes early on the first invalid way, otherwise at the last way.
  assign scan_end = cur_invalid || (k_q == LastIdx);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; req is only honoured in idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.req) state_d = StScan;
      StScan:  if (scan_end) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM status outputs.
  always_comb begin
    bus.busy = (state_q != StIdle);
    bus.done = (state_q == StDone);
  end

  // Datapath next state: snapshot capture, running minimum and result load.
  always_comb begin
    snap_cnt_d   = snap_cnt_q;
    snap_valid_d = snap_valid_q;
`ifdef LFU_LOCK_EN
    snap_lock_d  = snap_lock_q;
    vic_none_d   = vic_none_q;
`endif
    k_d          = k_q;
    best_idx_d   = best_idx_q;
    best_cnt_d   = best_cnt_q;
    found_d      = found_q;
    vic_idx_d    = vic_idx_q;
    vic_cnt_d    = vic_cnt_q;
    vic_inv_d    = vic_inv_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          for (int i = 0; i < SIZE; i++) begin
            snap_cnt_d[i] = bus.cnt_flat[i*CNT_W +: CNT_W];
          end
          snap_valid_d = bus.valid_mask;
`ifdef LFU_LOCK_EN
          snap_lock_d  = bus.lock_mask;
`endif
          k_d        = '0;
          best_cnt_d = '1;
          best_idx_d = '0;
          found_d    = 1'b0;
        end
      end
      StScan: begin
        if (cur_invalid) begin
          vic_idx_d = k_q;
          vic_cnt_d = '0;
          vic_inv_d = 1'b1;
`ifdef LFU_LOCK_EN
          vic_none_d = 1'b0;
`endif
        end else begin
          if (cur_better) begin
            best_cnt_d = cur_cnt;
            best_idx_d = k_q;
            found_d    = 1'b1;
          end
          if (k_q == LastIdx) begin
            vic_inv_d = 1'b0;
            if (found_d) begin
              vic_idx_d = best_idx_d;
              vic_cnt_d = best_cnt_d;
`ifdef LFU_LOCK_EN
              vic_none_d = 1'b0;
`endif
            end else begin
              // Every way locked and valid: nothing may be evicted.
              vic_idx_d = '0;
              vic_cnt_d = '0;
`ifdef LFU_LOCK_EN
              vic_none_d = 1'b1;
`endif
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StDone:  ;
      default: ;
    endcase
  end

  // Datapath registers; results hold until the next scan completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) begin
        snap_cnt_q[i] <= '0;
      end
      snap_valid_q <= '0;
`ifdef LFU_LOCK_EN
      snap_lock_q  <= '0;
      vic_none_q   <= 1'b0;
`endif
      k_q          <= '0;
      best_idx_q   <= '0;
      best_cnt_q   <= '0;
      found_q      <= 1'b0;
      vic_idx_q    <= '0;
      vic_cnt_q    <= '0;
      vic_inv_q    <= 1'b0;
    end else begin
      snap_cnt_q   <= snap_cnt_d;
      snap_valid_q <= snap_valid_d;
`ifdef LFU_LOCK_EN
      snap_lock_q  <= snap_lock_d;
      vic_none_q   <= vic_none_d;
`endif
      k_q          <= k_d;
      best_idx_q   <= best_idx_d;
      best_cnt_q   <= best_cnt_d;
      found_q      <= found_d;
      vic_idx_q    <= vic_idx_d;
      vic_cnt_q    <= vic_cnt_d;
      vic_inv_q    <= vic_inv_d;
    end
  end

  assign bus.victim_idx     = vic_idx_q;
  assign bus.victim_cnt     = vic_cnt_q;
  assign bus.victim_invalid = vic_inv_q;
`ifdef LFU_LOCK_EN
  assign bus.no_victim      = vic_none_q;
`else
  assign bus.no_victim      = 1'b0;
`endif

endmodule

// File: tb/tb_lfu_victim_select.sv
// Self-checking bench for lfu_victim_select (SIZE=4, CNT_W=8).
// Build option: LFU_LOCK_EN enables the lock-mask scenarios.
module tb_lfu_victim_select;

  typedef struct packed {
    logic       seen;
    logic       busy0;
    logic [7:0] lat;
    logic [1:0] idx;
    logic [7:0] cnt;
    logic       inv;
    logic       nov;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lfu_victim_select_if #(.SIZE(4), .CNT_W(8)) bus ();

  lfu_victim_select #(
    .SIZE  (4),
    .CNT_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  res_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [31:0] pack4(input logic [7:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic res_t exp_res(input int lat, input int idx, input int cnt,
                                   input bit inv, input bit nov);
    res_t r;
    r.seen  = 1'b1;
    r.busy0 = 1'b1;
    r.lat   = 8'(lat);
    r.idx   = 2'(idx);
    r.cnt   = 8'(cnt);
    r.inv   = inv;
    r.nov   = nov;
    return r;
  endfunction

  function automatic string show(input res_t r);
    return $sformatf("done=%0b busy=%0b lat=%0d idx=%0d cnt=%0d inv=%0b nov=%0b",
                     r.seen, r.busy0, r.lat, r.idx, r.cnt, r.inv, r.nov);
  endfunction

  // Issue one request once idle and wait (bounded) for done.
  task automatic do_req(input logic [31:0] cf, input logic [3:0] vm, output res_t o);
    int m;
    int guard;
    @(negedge clk);
    guard = 0;
    while (bus.busy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.cnt_flat   = cf;
    bus.valid_mask = vm;
    bus.req        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    o       = '0;
    o.busy0 = bus.busy;
    m       = 0;
    while (!bus.done && m < 20) begin
      @(negedge clk);
      m++;
    end
    o.seen = bus.done;
    o.lat  = 8'(m);
    o.idx  = bus.victim_idx;
    o.cnt  = bus.victim_cnt;
    o.inv  = bus.victim_invalid;
    o.nov  = bus.no_victim;
  endtask

  task automatic test_reset;
    logic [12:0] got;
    #12;
    got = {bus.busy, bus.done, bus.victim_idx, bus.victim_cnt, bus.victim_invalid,
           bus.no_victim};
    n_vec++;
    if (got !== 13'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_reset: busy/done got %b want 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_min_select;
    logic [31:0] cf [3];
    res_t got, e;
    cf[0] = pack4(8'd5, 8'd3, 8'd9, 8'd7);
    cf[1] = pack4(8'd0, 8'd200, 8'd17, 8'd1);
    cf[2] = pack4(8'd90, 8'd80, 8'd70, 8'd60);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       sb.push_back(exp_res(4, 1, 3, 1'b0, 1'b0));
        1:       sb.push_back(exp_res(4, 0, 0, 1'b0, 1'b0));
        default: sb.push_back(exp_res(4, 3, 60, 1'b0, 1'b0));
      endcase
      do_req(cf[i], 4'hF, got);
      e = sb.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL min_select[%0d]: got %s want %s", i, show(got), show(e));
      end
    end
  endtask

  task automatic test_invalid;
    logic [3:0] vm [3];
    res_t got, e;
    vm[0] = 4'b1011;
    vm[1] = 4'b0111;
    vm[2] = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       sb.push_back(exp_res(3, 2, 0, 1'b1, 1'b0));
        1:       sb.push_back(exp_res(4, 3, 0, 1'b1, 1'b0));
        default: sb.push_back(exp_res(1, 0, 0, 1'b1, 1'b0));
      endcase
      do_req(pack4(8'd5, 8'd3, 8'd9, 8'd7), vm[i], got);
      e = sb.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL invalid_way[%0d]: got %s want %s", i, show(got), show(e));
      end
    end
  endtask

  task automatic test_ties;
    res_t got, e;
    sb.push_back(exp_res(4, 1, 2, 1'b0, 1'b0));
    do_req(pack4(8'd4, 8'd2, 8'd2, 8'd2), 4'hF, got);
    e = sb.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL tie_low_index: got %s want %s", show(got), show(e));
    end
    sb.push_back(exp_res(4, 0, 255, 1'b0, 1'b0));
    do_req(32'hFFFF_FFFF, 4'hF, got);
    e = sb.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL all_ones: got %s want %s", show(got), show(e));
    end
  endtask

  task automatic test_snapshot;
    res_t got, e;
    int   m;
    int   extra;
    @(negedge clk);
    bus.cnt_flat   = pack4(8'd5, 8'd3, 8'd9, 8'd7);
    bus.valid_mask = 4'hF;
    bus.req        = 1'b1;
    sb.push_back(exp_res(4, 1, 3, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    got       = '0;
    got.busy0 = bus.busy;
    @(negedge clk);
    m = 1;
    bus.cnt_flat   = '0;
    bus.valid_mask = 4'h0;
    bus.req        = 1'b1;
    @(negedge clk);
    m = 2;
    bus.req = 1'b0;
    while (!bus.done && m < 20) begin
      @(negedge clk);
      m++;
    end
    got.seen = bus.done;
    got.lat  = 8'(m);
    got.idx  = bus.victim_idx;
    got.cnt  = bus.victim_cnt;
    got.inv  = bus.victim_invalid;
    got.nov  = bus.no_victim;
    e = sb.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL snapshot: got %s want %s", show(got), show(e));
    end
    // A req raised in the done cycle must not start a scan.
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL req_in_done: busy got %b want 0", bus.busy);
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    n_vec++;
    if (extra !== 0) begin
      n_err++;
      $display("FAIL single_done: extra done pulses got %0d want 0", extra);
    end
  endtask

  task automatic test_reset_mid_scan;
    logic [12:0] outs;
    res_t got, e;
    int   dones;
    @(negedge clk);
    bus.cnt_flat   = pack4(8'd5, 8'd3, 8'd9, 8'd7);
    bus.valid_mask = 4'hF;
    bus.req        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    outs = {bus.busy, bus.done, bus.victim_idx, bus.victim_cnt, bus.victim_invalid,
            bus.no_victim};
    n_vec++;
    if (outs !== 13'h0) begin
      n_err++;
      $display("FAIL reset_mid_scan: got %h want 0", outs);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    n_vec++;
    if (dones !== 0) begin
      n_err++;
      $display("FAIL aborted_scan: busy/done cycles got %0d want 0", dones);
    end
    sb.push_back(exp_res(1, 0, 0, 1'b1, 1'b0));
    do_req(pack4(8'd5, 8'd3, 8'd9, 8'd7), 4'b1110, got);
    e = sb.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL after_reset_req: got %s want %s", show(got), show(e));
    end
  endtask

`ifdef LFU_LOCK_EN
  task automatic test_lock;
    res_t got, e;
    logic [3:0] lm [3];
    logic [3:0] vm [3];
    lm[0] = 4'b0010;  vm[0] = 4'hF;
    lm[1] = 4'b1111;  vm[1] = 4'hF;
    lm[2] = 4'b1111;  vm[2] = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       sb.push_back(exp_res(4, 0, 5, 1'b0, 1'b0));
        1:       sb.push_back(exp_res(4, 0, 0, 1'b0, 1'b1));
        default: sb.push_back(exp_res(3, 2, 0, 1'b1, 1'b0));
      endcase
      bus.lock_mask = lm[i];
      do_req(pack4(8'd5, 8'd3, 8'd9, 8'd7), vm[i], got);
      e = sb.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL lock[%0d]: got %s want %s", i, show(got), show(e));
      end
    end
    bus.lock_mask = 4'h0;
  endtask
`endif

  initial begin
    bus.req        = 1'b0;
    bus.cnt_flat   = '0;
    bus.valid_mask = '0;
`ifdef LFU_LOCK_EN
    bus.lock_mask  = '0;
`endif
    test_reset();
    test_min_select();
    test_invalid();
    test_ties();
    test_snapshot();
    test_reset_mid_scan();
`ifdef LFU_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
